// File: rtl/id_issue_stage_pkg.sv
// Shared opcode encoding, instruction field slicing and per-opcode decode tables
// for the ID/issue stage and the WB/hazard logic that must agree with it.
package id_issue_stage_pkg;

    localparam logic [15:0] DEFAULT_NOP_IR = 16'h0000;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,  OP_HALT  = 5'd1,  OP_LOAD  = 5'd2,  OP_STORE = 5'd3,
        OP_ADD   = 5'd4,  OP_ADDI  = 5'd5,  OP_SUB   = 5'd6,  OP_SUBI  = 5'd7,
        OP_SHL   = 5'd8,  OP_SHR   = 5'd9,  OP_CAL   = 5'd10, OP_CAR   = 5'd11,
        OP_CMP   = 5'd12, OP_AND   = 5'd13, OP_OR    = 5'd14, OP_XOR   = 5'd15,
        OP_MOVI  = 5'd16, OP_ADDC  = 5'd17, OP_SUBC  = 5'd18, OP_JUMP  = 5'd24,
        OP_JZ    = 5'd26, OP_JNZ   = 5'd27, OP_JS    = 5'd28, OP_JNS   = 5'd29,
        OP_JC    = 5'd30, OP_JNC   = 5'd31
    } opcode_e;

    // Operand-source class: which register fields feed A/B/smdr and which immediate is used
    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0, SEL_RR   = 3'd1, SEL_RD_I8 = 3'd2,
        SEL_Z_I8  = 3'd3, SEL_R1_I4 = 3'd4, SEL_STORE = 3'd5
    } sel_e;

    function automatic opcode_e op_of(input logic [15:0] ir);
        return opcode_e'(ir[15:11]);
    endfunction

    function automatic logic [2:0] rd_of(input logic [15:0] ir);
        return ir[10:8];
    endfunction

    function automatic logic [2:0] r1_of(input logic [15:0] ir);
        return ir[6:4];
    endfunction

    function automatic logic [2:0] r2_of(input logic [15:0] ir);
        return ir[2:0];
    endfunction

    function automatic logic [7:0] imm8_of(input logic [15:0] ir);
        return ir[7:0];
    endfunction

    function automatic logic [3:0] imm4_of(input logic [15:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic writes_gr(input opcode_e op);
        case (op)
            OP_LOAD, OP_ADD, OP_ADDI, OP_MOVI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
            OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CAL, OP_CAR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic sel_e sel_of(input opcode_e op);
        case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: return SEL_RR;
            OP_ADDI, OP_SUBI, OP_JZ, OP_JNZ, OP_JS, OP_JNS, OP_JC, OP_JNC, OP_JUMP: return SEL_RD_I8;
            OP_MOVI: return SEL_Z_I8;
            OP_SHL, OP_SHR, OP_CAL, OP_CAR, OP_LOAD: return SEL_R1_I4;
            OP_STORE: return SEL_STORE;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/id_issue_stage_if.sv
// ID/issue stage bus: decode input, forwarding sources, WB port and EX-side outputs.
interface id_issue_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              enable;
    logic [15:0]       id_ir;
    logic              flush;
    logic [DATA_W-1:0] ex_alu_o;
    logic              mem_we;
    logic [REG_AW-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [15:0]       ex_ir;
    logic [DATA_W-1:0] reg_A;
    logic [DATA_W-1:0] reg_B;
    logic [DATA_W-1:0] smdr;
    logic              stall;

    modport master (
        output enable, id_ir, flush, ex_alu_o, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data,
        input  ex_ir, reg_A, reg_B, smdr, stall
    );

    modport slave (
        input  enable, id_ir, flush, ex_alu_o, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data,
        output ex_ir, reg_A, reg_B, smdr, stall
    );
endinterface

// File: rtl/id_issue_stage_gr_file.sv
// General register file: three asynchronous read ports, one synchronous write port.
module gr_file #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr0,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] regs_r [2**REG_AW];

    // Register storage: cleared on reset, written by WB
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata0 = regs_r[raddr0];
    assign rdata1 = regs_r[raddr1];
    assign rdata2 = regs_r[raddr2];
endmodule

// File: rtl/id_issue_stage.sv
// Decode/operand-issue stage: GR file, operand select with EX/MEM/WB forwarding,
// load-use stall and flush bubble insertion, registered EX-side outputs.
module id_issue_stage
    import id_issue_stage_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter int          REG_AW = 3,
    parameter logic [15:0] NOP_IR = DEFAULT_NOP_IR
) (
    input logic            clock,
    input logic            reset,
    id_issue_stage_if.slave bus
);
    opcode_e           id_op_s, ex_op_s;
    sel_e              sel_s;
    logic [REG_AW-1:0] rd_s, r1_s, r2_s, ex_rd_s;
    logic [DATA_W-1:0] gr_r1_s, gr_r2_s, gr_rd_s;
    logic [DATA_W-1:0] fwd_r1_s, fwd_r2_s, fwd_rd_s;
    logic [DATA_W-1:0] imm8_s, imm4_s;
    logic [DATA_W-1:0] next_a_s, next_b_s, next_smdr_s;
    logic              use_r1_s, use_r2_s, use_rd_s;
    logic              ex_fwd_ok_s, hazard_s;
    logic [15:0]       ex_ir_r;
    logic [DATA_W-1:0] reg_a_r, reg_b_r, smdr_r;

    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_AW-1:0] idx,   input logic [DATA_W-1:0] gr_val,
        input logic ex_ok,              input logic [REG_AW-1:0] ex_rd, input logic [DATA_W-1:0] ex_val,
        input logic m_we,               input logic [REG_AW-1:0] m_rd,  input logic [DATA_W-1:0] m_val,
        input logic w_we,               input logic [REG_AW-1:0] w_rd,  input logic [DATA_W-1:0] w_val
    );
        if (ex_ok && ex_rd == idx)      return ex_val;
        else if (m_we && m_rd == idx)   return m_val;
        else if (w_we && w_rd == idx)   return w_val;
        else                            return gr_val;
    endfunction

    assign id_op_s = op_of(bus.id_ir);
    assign ex_op_s = op_of(ex_ir_r);
    assign sel_s   = sel_of(id_op_s);
    assign rd_s    = REG_AW'(rd_of(bus.id_ir));
    assign r1_s    = REG_AW'(r1_of(bus.id_ir));
    assign r2_s    = REG_AW'(r2_of(bus.id_ir));
    assign ex_rd_s = REG_AW'(rd_of(ex_ir_r));
    assign imm8_s  = DATA_W'(imm8_of(bus.id_ir));
    assign imm4_s  = DATA_W'(imm4_of(bus.id_ir));

    gr_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) gr (
        .clock  (clock),       .reset  (reset),
        .we     (bus.wb_we),   .waddr  (bus.wb_rd),   .wdata  (bus.wb_data),
        .raddr0 (r1_s),        .raddr1 (r2_s),        .raddr2 (rd_s),
        .rdata0 (gr_r1_s),     .rdata1 (gr_r2_s),     .rdata2 (gr_rd_s)
    );

    // A LOAD in EX has no result yet; its consumers are covered by the stall instead
    assign ex_fwd_ok_s = writes_gr(ex_op_s) && (ex_op_s != OP_LOAD);

    assign fwd_r1_s = fwd(r1_s, gr_r1_s, ex_fwd_ok_s, ex_rd_s, bus.ex_alu_o,
                          bus.mem_we, bus.mem_rd, bus.mem_data, bus.wb_we, bus.wb_rd, bus.wb_data);
    assign fwd_r2_s = fwd(r2_s, gr_r2_s, ex_fwd_ok_s, ex_rd_s, bus.ex_alu_o,
                          bus.mem_we, bus.mem_rd, bus.mem_data, bus.wb_we, bus.wb_rd, bus.wb_data);
    assign fwd_rd_s = fwd(rd_s, gr_rd_s, ex_fwd_ok_s, ex_rd_s, bus.ex_alu_o,
                          bus.mem_we, bus.mem_rd, bus.mem_data, bus.wb_we, bus.wb_rd, bus.wb_data);

    // Operand selection and source-usage flags per operand class
    always_comb begin
        next_a_s    = {DATA_W{1'b0}};
        next_b_s    = {DATA_W{1'b0}};
        next_smdr_s = {DATA_W{1'b0}};
        use_r1_s    = 1'b0;
        use_r2_s    = 1'b0;
        use_rd_s    = 1'b0;
        case (sel_s)
            SEL_RR: begin
                next_a_s = fwd_r1_s;  next_b_s = fwd_r2_s;
                use_r1_s = 1'b1;      use_r2_s = 1'b1;
            end
            SEL_RD_I8: begin
                next_a_s = fwd_rd_s;  next_b_s = imm8_s;  use_rd_s = 1'b1;
            end
            SEL_Z_I8: begin
                next_b_s = imm8_s;
            end
            SEL_R1_I4: begin
                next_a_s = fwd_r1_s;  next_b_s = imm4_s;  use_r1_s = 1'b1;
            end
            SEL_STORE: begin
                next_a_s = fwd_r1_s;  next_b_s = imm4_s;  next_smdr_s = fwd_rd_s;
                use_r1_s = 1'b1;      use_rd_s = 1'b1;
            end
            default: begin
                next_a_s = {DATA_W{1'b0}};
            end
        endcase
    end

    assign hazard_s  = (ex_op_s == OP_LOAD) &&
                       ((use_r1_s && ex_rd_s == r1_s) ||
                        (use_r2_s && ex_rd_s == r2_s) ||
                        (use_rd_s && ex_rd_s == rd_s));
    assign bus.stall = hazard_s && !bus.flush;

    // EX-side pipeline registers: flush and stall both inject a bubble
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_ir_r <= NOP_IR;
            reg_a_r <= {DATA_W{1'b0}};
            reg_b_r <= {DATA_W{1'b0}};
            smdr_r  <= {DATA_W{1'b0}};
        end else if (bus.enable) begin
            if (bus.flush || hazard_s) begin
                ex_ir_r <= NOP_IR;
                reg_a_r <= {DATA_W{1'b0}};
                reg_b_r <= {DATA_W{1'b0}};
                smdr_r  <= {DATA_W{1'b0}};
            end else begin
                ex_ir_r <= bus.id_ir;
                reg_a_r <= next_a_s;
                reg_b_r <= next_b_s;
                smdr_r  <= next_smdr_s;
            end
        end
    end

    assign bus.ex_ir = ex_ir_r;
    assign bus.reg_A = reg_a_r;
    assign bus.reg_B = reg_b_r;
    assign bus.smdr  = smdr_r;
endmodule
